// File: rtl/sdram_probe_ctrl.sv
`timescale 1ns/1ps
// SDRAM command-port sequencer: signature write/read-back probe to size the module,
// result reported on cfg, followed by a paced zero-clear sweep of the memory.
module sdram_probe_ctrl #(
  parameter int unsigned       ADDR_W  = 27,
  parameter logic [ADDR_W-1:0] CLR_END = ADDR_W'(32'h01FF_FFFF),
  parameter int unsigned       CLR_GAP = 32,
  parameter int unsigned       TIMEOUT = 1023
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              rescan,
  input  logic              sdram_ready,
  input  logic [15:0]       sdram_dout,
  output logic [ADDR_W-1:0] sdram_addr,
  output logic [15:0]       sdram_din,
  output logic              sdram_rd,
  output logic              sdram_we,
  output logic [15:0]       cfg,
  output logic              clearing
);

  localparam int unsigned GAP_W = $clog2(CLR_GAP);
  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

  localparam logic [ADDR_W-1:0] A_SIG3  = ADDR_W'(32'h0400_0000);
  localparam logic [ADDR_W-1:0] A_SIG2  = ADDR_W'(32'h0200_0000);
  localparam logic [ADDR_W-1:0] A_SIG1  = ADDR_W'(32'h0000_0000);
  localparam logic [ADDR_W-1:0] A_GUARD = ADDR_W'(32'h0100_0000);
  localparam logic [15:0] D_SIG3  = 16'd3128;
  localparam logic [15:0] D_SIG2  = 16'd2064;
  localparam logic [15:0] D_SIG1  = 16'd1032;
  localparam logic [15:0] D_GUARD = 16'd12345;

  typedef enum logic [4:0] {
    S_INIT, S_W3, S_GW3, S_W2, S_GW2, S_W1, S_GW1, S_W0, S_GW0,
    S_R3, S_GR3, S_R2, S_GR2, S_R1, S_GR1, S_CHK, S_CLEAR, S_DONE
  } state_t;

  state_t            r_state, w_next;
  logic              r_rd, r_we, r_clearing;
  logic [ADDR_W-1:0] r_addr, r_clr_addr;
  logic [15:0]       r_din, r_cfg;
  logic [GAP_W-1:0]  r_gap;
  logic [TMO_W-1:0]  r_tmo;

  logic              w_rd, w_we, w_clearing;
  logic [ADDR_W-1:0] w_addr, w_clr_addr;
  logic [15:0]       w_din, w_cfg;
  logic [GAP_W-1:0]  w_gap;
  logic [TMO_W-1:0]  w_tmo, w_tmo_inc;
  logic              w_wait, w_rescan, w_tmo_hit, w_clr_last;

  // States that sit on sdram_ready; the clear state only at its slot
  assign w_wait = (r_state inside {S_INIT, S_W3, S_W2, S_W1, S_W0, S_R3, S_R2, S_R1, S_CHK})
                || (r_state == S_CLEAR && r_gap == '0);
  assign w_rescan   = rescan && (r_state != S_INIT);
  assign w_tmo_inc  = (r_tmo == TMO_W'(TIMEOUT)) ? r_tmo : r_tmo + TMO_W'(1);
  assign w_tmo_hit  = w_wait && !sdram_ready && (w_tmo_inc == TMO_W'(TIMEOUT));
  assign w_clr_last = (r_clr_addr == CLR_END);

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      r_state    <= S_INIT;
      r_rd       <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_din      <= '0;
      r_cfg      <= '0;
      r_clearing <= 1'b0;
      r_clr_addr <= '0;
      r_gap      <= '0;
      r_tmo      <= '0;
    end else begin
      r_state    <= w_next;
      r_rd       <= w_rd;
      r_we       <= w_we;
      r_addr     <= w_addr;
      r_din      <= w_din;
      r_cfg      <= w_cfg;
      r_clearing <= w_clearing;
      r_clr_addr <= w_clr_addr;
      r_gap      <= w_gap;
      r_tmo      <= w_tmo;
    end
  end

  always_comb begin
    w_next = r_state;
    if (w_rescan) begin
      w_next = S_INIT;
    end else if (w_tmo_hit) begin
      w_next = S_DONE;
    end else begin
      case (r_state)
        S_INIT:  if (sdram_ready) w_next = S_W3;
        S_W3:    if (sdram_ready) w_next = S_GW3;
        S_GW3:   w_next = S_W2;
        S_W2:    if (sdram_ready) w_next = S_GW2;
        S_GW2:   w_next = S_W1;
        S_W1:    if (sdram_ready) w_next = S_GW1;
        S_GW1:   w_next = S_W0;
        S_W0:    if (sdram_ready) w_next = S_GW0;
        S_GW0:   w_next = S_R3;
        S_R3:    if (sdram_ready) w_next = S_GR3;
        S_GR3:   w_next = S_R2;
        S_R2:    if (sdram_ready) w_next = S_GR2;
        S_GR2:   w_next = S_R1;
        S_R1:    if (sdram_ready) w_next = S_GR1;
        S_GR1:   w_next = S_CHK;
        S_CHK:   if (sdram_ready) w_next = S_CLEAR;
        S_CLEAR: if (w_wait && sdram_ready && w_clr_last) w_next = S_DONE;
        S_DONE:  w_next = S_DONE;
        default: w_next = S_INIT;
      endcase
    end
  end

  // Command pulses and result latching; each read result is sampled as the next read issues
  always_comb begin
    w_rd       = 1'b0;
    w_we       = 1'b0;
    w_addr     = r_addr;
    w_din      = r_din;
    w_cfg      = r_cfg;
    w_clearing = r_clearing;
    w_clr_addr = r_clr_addr;
    w_gap      = r_gap;
    w_tmo      = (w_wait && !sdram_ready) ? w_tmo_inc : '0;
    if (w_rescan) begin
      w_clearing = 1'b0;
      w_tmo      = '0;
    end else if (w_tmo_hit) begin
      w_cfg      = 16'hC000;
      w_clearing = 1'b0;
      w_tmo      = '0;
    end else if (sdram_ready) begin
      case (r_state)
        S_INIT: w_cfg = '0;
        S_W3: begin w_we = 1'b1; w_addr = A_SIG3;  w_din = D_SIG3;  end
        S_W2: begin w_we = 1'b1; w_addr = A_SIG2;  w_din = D_SIG2;  end
        S_W1: begin w_we = 1'b1; w_addr = A_SIG1;  w_din = D_SIG1;  end
        S_W0: begin w_we = 1'b1; w_addr = A_GUARD; w_din = D_GUARD; end
        S_R3: begin w_rd = 1'b1; w_addr = A_SIG3; end
        S_R2: begin
          w_cfg[2] = (sdram_dout == D_SIG3);
          w_rd     = 1'b1;
          w_addr   = A_SIG2;
        end
        S_R1: begin
          w_cfg[1] = (sdram_dout == D_SIG2);
          w_rd     = 1'b1;
          w_addr   = A_SIG1;
        end
        S_CHK: begin
          w_cfg[0]   = (sdram_dout == D_SIG1);
          w_cfg[15]  = 1'b1;
          w_clearing = 1'b1;
          w_clr_addr = '0;
          w_gap      = '0;
        end
        default: ;
      endcase
    end
    // Clear pacing runs regardless of ready; only the slot itself waits on it
    if (!w_rescan && !w_tmo_hit && r_state == S_CLEAR) begin
      if (r_gap != '0) begin
        w_gap = r_gap - GAP_W'(1);
      end else if (sdram_ready) begin
        w_we   = 1'b1;
        w_addr = r_clr_addr;
        w_din  = '0;
        w_gap  = GAP_W'(CLR_GAP - 1);
        if (w_clr_last) w_clearing = 1'b0;
        else            w_clr_addr = r_clr_addr + ADDR_W'(1);
      end
    end
  end

  assign sdram_rd   = r_rd;
  assign sdram_we   = r_we;
  assign sdram_addr = r_addr;
  assign sdram_din  = r_din;
  assign cfg        = r_cfg;
  assign clearing   = r_clearing;

endmodule

// File: tb/tb_sdram_probe_ctrl.sv
`timescale 1ns/1ps
// Bench for sdram_probe_ctrl: aliasing SDRAM model with ready handshake, command log,
// and reference expectations derived from the probe/clear rules.
module tb_sdram_probe_ctrl;

  localparam int unsigned ADDR_W  = 27;
  localparam int unsigned CLR_GAP = 4;
  localparam int unsigned TIMEOUT = 20;
  localparam logic [ADDR_W-1:0] CLR_END = 27'd15;
  localparam int N_PROBE = 7;
  localparam int N_CLR   = 16;
  localparam logic [26:0] MASK64 = 27'h7FF_FFFF;
  localparam logic [26:0] MASK32 = 27'h3FF_FFFF;
  localparam logic [26:0] MASK16 = 27'h1FF_FFFF;

  logic              clk_sys = 1'b0;
  logic              reset_n, rescan, sdram_ready;
  logic [15:0]       sdram_dout;
  logic [ADDR_W-1:0] sdram_addr;
  logic [15:0]       sdram_din, cfg;
  logic              sdram_rd, sdram_we, clearing;

  typedef struct {
    logic        we;
    logic        rd;
    logic [26:0] addr;
    logic [15:0] din;
    int          cyc;
  } cmd_t;

  cmd_t        log_q[$];
  logic [15:0] mem [logic [26:0]];
  logic [26:0] cur_mask;
  int          cyc, last_cmd_cyc, n_viol, drop_at, drop_len, drop_cnt;
  int          n_tests, n_fail;
  bit          busy, stuck, ready_at_edge;

  sdram_probe_ctrl #(
    .ADDR_W (ADDR_W),
    .CLR_END(CLR_END),
    .CLR_GAP(CLR_GAP),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .rescan     (rescan),
    .sdram_ready(sdram_ready),
    .sdram_dout (sdram_dout),
    .sdram_addr (sdram_addr),
    .sdram_din  (sdram_din),
    .sdram_rd   (sdram_rd),
    .sdram_we   (sdram_we),
    .cfg        (cfg),
    .clearing   (clearing)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected cfg: write the signatures into an aliased memory, read them back
  function automatic logic [15:0] exp_cfg(input logic [26:0] mask);
    logic [15:0] m [logic [26:0]];
    logic [26:0] a3, a2, a1;
    a3 = 27'h400_0000 & mask;
    a2 = 27'h200_0000 & mask;
    a1 = 27'h000_0000 & mask;
    m[a3] = 16'd3128;
    m[a2] = 16'd2064;
    m[a1] = 16'd1032;
    m[27'h100_0000 & mask] = 16'd12345;
    return {1'b1, 1'b0, 11'd0, m[a3] == 16'd3128, m[a2] == 16'd2064, m[a1] == 16'd1032};
  endfunction

  function automatic cmd_t exp_cmd(input int i);
    cmd_t e;
    e.we = 1'b0; e.rd = 1'b0; e.addr = '0; e.din = '0; e.cyc = 0;
    case (i)
      0: begin e.we = 1'b1; e.addr = 27'h400_0000; e.din = 16'd3128;  end
      1: begin e.we = 1'b1; e.addr = 27'h200_0000; e.din = 16'd2064;  end
      2: begin e.we = 1'b1; e.addr = 27'h000_0000; e.din = 16'd1032;  end
      3: begin e.we = 1'b1; e.addr = 27'h100_0000; e.din = 16'd12345; end
      4: begin e.rd = 1'b1; e.addr = 27'h400_0000; end
      5: begin e.rd = 1'b1; e.addr = 27'h200_0000; end
      6: begin e.rd = 1'b1; e.addr = 27'h000_0000; end
      default: begin e.we = 1'b1; e.addr = 27'(i - N_PROBE); e.din = 16'h0; end
    endcase
    return e;
  endfunction

  // One clock: sample DUT after the edge, log commands, update memory and drive ready/dout
  task automatic step();
    cmd_t        c;
    logic [26:0] a;
    @(posedge clk_sys);
    #1;
    cyc++;
    busy = 1'b0;
    if (sdram_we || sdram_rd) begin
      if (sdram_we && sdram_rd) n_viol++;
      if (last_cmd_cyc == cyc - 1) n_viol++;
      if (!ready_at_edge) n_viol++;
      c.we = sdram_we; c.rd = sdram_rd; c.addr = sdram_addr; c.din = sdram_din; c.cyc = cyc;
      log_q.push_back(c);
      a = sdram_addr & cur_mask;
      if (sdram_we) mem[a] = sdram_din;
      else          sdram_dout = mem.exists(a) ? mem[a] : 16'hFFFF;
      last_cmd_cyc = cyc;
      busy = 1'b1;
    end
    if (drop_cnt > 0) drop_cnt--;
    if (sdram_we && log_q.size() > N_PROBE && drop_at >= 0 && int'(sdram_addr) == drop_at)
      drop_cnt = drop_len;
    sdram_ready   = !busy && drop_cnt == 0 && !stuck;
    ready_at_edge = sdram_ready;
  endtask

  // Run a full probe + clear from INIT and compare against the reference sequence
  task automatic do_probe(input logic [26:0] mask, input int d_at, input int d_len);
    logic [15:0] ecfg;
    bit          rose, fell;
    cmd_t        e;
    int          sp, exp_sp, j;
    cur_mask = mask; drop_at = d_at; drop_len = d_len;
    log_q.delete();
    ecfg = exp_cfg(mask);
    rose = 1'b0; fell = 1'b0;
    for (int i = 0; i < 800 && !fell; i++) begin
      step();
      if (!rose && clearing) begin
        rose = 1'b1;
        check("cfg_at_clear_rise", 64'(cfg), 64'(ecfg));
      end else if (rose && !clearing) begin
        fell = 1'b1;
      end
    end
    check("clear_window", 64'({rose, fell}), 64'(2'b11));
    repeat (3 * CLR_GAP + 20) step();
    check("cmd_count", 64'(log_q.size()), 64'(N_PROBE + N_CLR));
    for (int i = 0; i < log_q.size() && i < N_PROBE + N_CLR; i++) begin
      e = exp_cmd(i);
      check($sformatf("cmd%0d", i),
            64'({log_q[i].we, log_q[i].rd, log_q[i].addr, log_q[i].we ? log_q[i].din : 16'h0}),
            64'({e.we, e.rd, e.addr, e.din}));
      if (i > N_PROBE) begin
        j      = i - N_PROBE;
        sp     = log_q[i].cyc - log_q[i-1].cyc;
        exp_sp = (d_at >= 0 && j - 1 == d_at && d_len + 1 > int'(CLR_GAP)) ? d_len + 1 : int'(CLR_GAP);
        check($sformatf("clr_spacing%0d", j), 64'(sp), 64'(exp_sp));
      end
    end
    check("cfg_final", 64'(cfg), 64'(ecfg));
    check("clearing_final", 64'(clearing), 64'(0));
    drop_at = -1;
  endtask

  task automatic rescan_from_done();
    logic [15:0] prev;
    prev   = cfg;
    rescan = 1'b1;
    step();
    rescan = 1'b0;
    check("rescan_cfg_kept", 64'(cfg), 64'(prev));
    check("rescan_quiet", 64'({sdram_rd, sdram_we, clearing}), 64'(0));
  endtask

  initial begin
    logic [26:0] m;
    int          k;
    bit          found;
    n_tests = 0; n_fail = 0; n_viol = 0;
    cyc = 0; last_cmd_cyc = -10;
    reset_n = 1'b0; rescan = 1'b0; sdram_ready = 1'b1; sdram_dout = '0;
    stuck = 1'b0; busy = 1'b0; ready_at_edge = 1'b1;
    drop_at = -1; drop_len = 0; drop_cnt = 0; cur_mask = MASK64;

    // Reset state
    repeat (3) step();
    check("rst_cmd", 64'({sdram_rd, sdram_we}), 64'(0));
    check("rst_addr_din", 64'({sdram_addr, sdram_din}), 64'(0));
    check("rst_cfg_clearing", 64'({cfg, clearing}), 64'(0));
    reset_n = 1'b1;

    // Full 64MB part
    do_probe(MASK64, -1, 0);

    // Rescan from DONE with randomly sized parts
    for (int r = 0; r < 4; r++) begin
      case ($urandom_range(0, 2))
        0:       m = MASK64;
        1:       m = MASK32;
        default: m = MASK16;
      endcase
      rescan_from_done();
      do_probe(m, -1, 0);
    end
    rescan_from_done();
    do_probe(MASK32, -1, 0);
    rescan_from_done();
    do_probe(MASK16, -1, 0);

    // Ready withheld at a clear slot: 10 cycles, then a random length
    rescan_from_done();
    do_probe(MASK64, int'($urandom_range(1, 14)), 10);
    rescan_from_done();
    do_probe(MASK64, int'($urandom_range(0, 14)), int'($urandom_range(1, 12)));

    // Rescan landing on a command slot mid-probe suppresses the command
    rescan_from_done();
    k = int'($urandom_range(1, 6));
    repeat (2 * k - 1) step();
    rescan = 1'b1;
    step();
    rescan = 1'b0;
    check("rescan_suppress", 64'({sdram_rd, sdram_we}), 64'(0));
    do_probe(MASK64, -1, 0);

    // Reset right after the clear write at address 7
    rescan_from_done();
    log_q.delete();
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      step();
      if (log_q.size() > N_PROBE && log_q[$].we && log_q[$].addr == 27'd7) found = 1'b1;
    end
    check("reached_clear_addr7", 64'(found), 64'(1));
    reset_n = 1'b0;
    step();
    check("midclear_rst_outputs",
          64'({sdram_rd, sdram_we, clearing, cfg}), 64'(0));
    check("midclear_rst_addr_din", 64'({sdram_addr, sdram_din}), 64'(0));
    reset_n = 1'b1;
    do_probe(MASK64, -1, 0);

    // Ready stuck low from INIT: timeout, then no commands ever
    reset_n = 1'b0;
    stuck   = 1'b1;
    step();
    reset_n = 1'b1;
    log_q.delete();
    repeat (18) step();
    check("tmo_before", 64'({cfg, clearing}), 64'(0));
    repeat (4) step();
    check("tmo_cfg", 64'(cfg), 64'(16'hC000));
    check("tmo_clearing", 64'(clearing), 64'(0));
    stuck = 1'b0;
    repeat (30) step();
    check("tmo_no_cmds", 64'(log_q.size()), 64'(0));
    check("tmo_cfg_held", 64'(cfg), 64'(16'hC000));
    rescan_from_done();
    do_probe(MASK64, -1, 0);

    check("protocol_violations", 64'(n_viol), 64'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
